tenkey_scan: RTL and testbench

Matrix-keypad scanner and debouncer that drives the 4x3 keypad on the lock panel. It produces the one-hot `tenkey[9:0]` digit strobe consumed by the electronic-lock core, plus `close` and `clear` strobes for the `#` and `*` keys. It sits between the keypad pins and the lock core, all in the single system clock domain.

---
 rtl/tenkey_scan.sv | 183 ++++++++++++++++++
 tb/tb_tenkey_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tenkey_scan.sv
// 4x3 keypad column scanner with row synchronizer, per-scan decode and debounce FSM.
// Emits one-cycle one-hot digit strobes plus close (#) and clear (*) strobes.
module tenkey_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [2:0] col,
  input  logic [3:0] row,
  output logic [9:0] tenkey,
  output logic       close,
  output logic       clear
);

  localparam int unsigned   DivW      = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0] DivMax  = DivW'(SCAN_DIV - 1);
  localparam logic [3:0]    DebCnt    = 4'(DEBOUNCE);
  localparam logic [3:0]    CodeClear = 4'd10;
  localparam logic [3:0]    CodeClose = 4'd11;
  localparam logic [3:0]    CodeNone  = 4'd15;

  typedef enum logic [1:0] {StScan, StDeb, StHold} state_e;

  logic [3:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      colidx_q, colidx_d;
  logic [11:0]     acc_q, acc_d, keys_now;
  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d, cnt_q, cnt_d;
  logic [9:0]      tenkey_q, tenkey_d;
  logic            close_q, close_d, clear_q, clear_d;
  logic            sample, scan_end, emit;
  logic [3:0]      code, emit_code, key_idx;

  assign sample   = (div_q == DivMax);
  assign scan_end = sample && (colidx_q == 2'd2);

  always_comb begin
    div_d    = div_q + 1'b1;
    colidx_d = colidx_q;
    if (sample) begin
      div_d    = '0;
      colidx_d = (colidx_q == 2'd2) ? 2'd0 : colidx_q + 2'd1;
    end
  end

  always_comb begin
    unique case (colidx_q)
      2'd0:    col = 3'b001;
      2'd1:    col = 3'b010;
      default: col = 3'b100;
    endcase
  end

  // keys_now folds the current column's sample in so scan end sees all 12 bits.
  always_comb begin
    keys_now = acc_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (2'(c) == colidx_q) keys_now[r*3+c] = row_sync_q[r];
        end
      end
    end
    acc_d = scan_end ? '0 : keys_now;
  end

  always_comb begin
    key_idx = '0;
    for (int k = 0; k < 12; k++) begin
      if (keys_now[k]) key_idx = 4'(k);
    end
    code = CodeNone;
    if ($countones(keys_now) == 1) begin
      if (key_idx < 4'd9)       code = key_idx + 4'd1;
      else if (key_idx == 4'd9)  code = CodeClear;
      else if (key_idx == 4'd10) code = 4'd0;
      else                       code = CodeClose;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_code = cand_q;
    if (scan_end) begin
      unique case (state_q)
        StScan: begin
          if (code != CodeNone) begin
            cand_d = code;
            if (DEBOUNCE == 1) begin
              emit      = 1'b1;
              emit_code = code;
              state_d   = StHold;
              cnt_d     = '0;
            end else begin
              state_d = StDeb;
              cnt_d   = 4'd1;
            end
          end
        end
        StDeb: begin
          if (code == cand_q) begin
            if (cnt_q + 4'd1 == DebCnt) begin
              emit    = 1'b1;
              state_d = StHold;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = StScan;
            cnt_d   = '0;
          end
        end
        StHold: begin
          // Any key seen restarts the release count, so a new key waits for full release.
          if (code == CodeNone) begin
            if (cnt_q + 4'd1 == DebCnt) begin
              state_d = StScan;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = StScan;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tenkey_d = '0;
    close_d  = 1'b0;
    clear_d  = 1'b0;
    if (emit) begin
      if (emit_code == CodeClose)      close_d = 1'b1;
      else if (emit_code == CodeClear) clear_d = 1'b1;
      else if (emit_code < 4'd10)      tenkey_d[emit_code] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '0;
      row_sync_q <= '0;
      div_q      <= '0;
      colidx_q   <= '0;
      acc_q      <= '0;
      state_q    <= StScan;
      cand_q     <= '0;
      cnt_q      <= '0;
      tenkey_q   <= '0;
      close_q    <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      div_q      <= div_d;
      colidx_q   <= colidx_d;
      acc_q      <= acc_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      tenkey_q   <= tenkey_d;
      close_q    <= close_d;
      clear_q    <= clear_d;
    end
  end

  assign tenkey = tenkey_q;
  assign close  = close_q;
  assign clear  = clear_q;

endmodule

// File: tb/tb_tenkey_scan.sv
// Directed bench for tenkey_scan: keypad model driven from a pressed-key mask,
// strobe monitor counting pulses, one task per scenario.
module tb_tenkey_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  col;
  logic [3:0]  row;
  logic [9:0]  tenkey;
  logic        close;
  logic        clear;
  logic [11:0] pressed = '0;  // bit r*3+c

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tk_total = 0;
  int close_total = 0;
  int clear_total = 0;
  int wide_total = 0;
  int multi_total = 0;
  int last_cyc = 0;
  logic [9:0] last_tk = '0;
  logic prev_any = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = |(pressed[r*3 +: 3] & col);
  end

  tenkey_scan dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .col    (col),
    .row    (row),
    .tenkey (tenkey),
    .close  (close),
    .clear  (clear)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tenkey != '0) begin
      tk_total <= tk_total + 1;
      last_tk  <= tenkey;
      last_cyc <= cyc;
    end
    if (close) close_total <= close_total + 1;
    if (clear) clear_total <= clear_total + 1;
    if (((tenkey != '0) || close || clear) && prev_any) wide_total <= wide_total + 1;
    if ($countones({tenkey, close, clear}) > 1) multi_total <= multi_total + 1;
    prev_any <= (tenkey != '0) || close || clear;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] exp;
    rst_n = 1'b0;
    step(3);
    checks++; if (col !== 3'b001) begin errors++; $display("FAIL reset_col got %b want 001", col); end
    checks++; if (tenkey !== 10'b0) begin errors++; $display("FAIL reset_tenkey got %b want 0", tenkey); end
    checks++; if (close !== 1'b0) begin errors++; $display("FAIL reset_close got %b want 0", close); end
    checks++; if (clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b want 0", clear); end
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      exp = 3'b001 << ((k / 4) % 3);
      checks++;
      if (col !== exp) begin
        errors++;
        $display("FAIL col_step k=%0d got %b want %b", k, col, exp);
      end
      step(1);
    end
    step(6);  // now mid-scan in column 1
    rst_n = 1'b0;
    #1;
    checks++; if (col !== 3'b001) begin errors++; $display("FAIL midreset_col got %b want 001", col); end
    checks++;
    if ({tenkey, close, clear} !== 12'b0) begin
      errors++;
      $display("FAIL midreset_outs got %b want 0", {tenkey, close, clear});
    end
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_single_press;
    int base, cbase, lbase, press_cyc;
    base = tk_total; cbase = close_total; lbase = clear_total;
    pressed[6] = 1'b1;  // '7'
    press_cyc = cyc;
    step(200);
    checks++; if (tk_total - base != 1) begin errors++; $display("FAIL single_count got %0d want 1", tk_total - base); end
    checks++; if (last_tk !== 10'b0010000000) begin errors++; $display("FAIL single_code got %b want 0010000000", last_tk); end
    checks++;
    if (last_cyc - press_cyc > 51 || last_cyc - press_cyc < 1) begin
      errors++;
      $display("FAIL single_latency got %0d want 1..51", last_cyc - press_cyc);
    end
    checks++;
    if (close_total != cbase || clear_total != lbase) begin
      errors++;
      $display("FAIL single_fkeys got %0d/%0d want %0d/%0d", close_total, clear_total, cbase, lbase);
    end
    pressed = '0;
    step(60);
    checks++; if (tk_total - base != 1) begin errors++; $display("FAIL single_release got %0d want 1", tk_total - base); end
  endtask

  task automatic test_bounce;
    int base;
    base = tk_total;
    for (int i = 0; i < 5; i++) begin
      pressed[3] = 1'b1;  // '4'
      step(12);
      pressed = '0;
      step(12);
    end
    checks++; if (tk_total - base != 0) begin errors++; $display("FAIL bounce_none got %0d want 0", tk_total - base); end
    pressed[3] = 1'b1;
    step(48);
    pressed = '0;
    step(60);
    checks++; if (tk_total - base != 1) begin errors++; $display("FAIL bounce_hold got %0d want 1", tk_total - base); end
    checks++; if (last_tk !== 10'b0000010000) begin errors++; $display("FAIL bounce_code got %b want 0000010000", last_tk); end
  endtask

  task automatic test_multi_key;
    int base;
    base = tk_total;
    pressed[0] = 1'b1;  // '1'
    pressed[4] = 1'b1;  // '5'
    step(100);
    checks++; if (tk_total - base != 0) begin errors++; $display("FAIL multi_none got %0d want 0", tk_total - base); end
    pressed[0] = 1'b0;
    step(60);
    checks++; if (tk_total - base != 1) begin errors++; $display("FAIL multi_single got %0d want 1", tk_total - base); end
    checks++; if (last_tk !== 10'b0000100000) begin errors++; $display("FAIL multi_code got %b want 0000100000", last_tk); end
    pressed = '0;
    step(60);
  endtask

  task automatic test_function_keys;
    int base, cbase, lbase;
    base = tk_total; cbase = close_total; lbase = clear_total;
    pressed[11] = 1'b1;  // '#'
    step(100);
    checks++; if (close_total - cbase != 1) begin errors++; $display("FAIL close_count got %0d want 1", close_total - cbase); end
    checks++; if (tk_total - base != 0) begin errors++; $display("FAIL close_tenkey got %0d want 0", tk_total - base); end
    checks++; if (clear_total - lbase != 0) begin errors++; $display("FAIL close_clear got %0d want 0", clear_total - lbase); end
    pressed = '0;
    step(48);
    pressed[9] = 1'b1;  // '*'
    step(100);
    checks++; if (clear_total - lbase != 1) begin errors++; $display("FAIL clear_count got %0d want 1", clear_total - lbase); end
    checks++; if (close_total - cbase != 1) begin errors++; $display("FAIL clear_close got %0d want 1", close_total - cbase); end
    checks++; if (tk_total - base != 0) begin errors++; $display("FAIL clear_tenkey got %0d want 0", tk_total - base); end
    pressed = '0;
    step(60);
  endtask

  task automatic test_rearm_reset;
    int base;
    base = tk_total;
    pressed[2] = 1'b1;  // '3'
    step(500);
    checks++; if (tk_total - base != 1) begin errors++; $display("FAIL rearm_first got %0d want 1", tk_total - base); end
    checks++; if (last_tk !== 10'b0000001000) begin errors++; $display("FAIL rearm_code got %b want 0000001000", last_tk); end
    pressed = '0;
    step(48);
    pressed[2] = 1'b1;
    step(100);
    checks++; if (tk_total - base != 2) begin errors++; $display("FAIL rearm_second got %0d want 2", tk_total - base); end
    pressed = '0;
    step(60);
    base = tk_total;
    pressed[8] = 1'b1;  // '9'
    step(24);
    rst_n = 1'b0;
    #1;
    checks++; if (col !== 3'b001) begin errors++; $display("FAIL rst9_col got %b want 001", col); end
    checks++; if (tenkey !== 10'b0) begin errors++; $display("FAIL rst9_tenkey got %b want 0", tenkey); end
    step(3);
    checks++; if (tk_total - base != 0) begin errors++; $display("FAIL rst9_none got %0d want 0", tk_total - base); end
    rst_n = 1'b1;
    step(80);
    checks++; if (tk_total - base != 1) begin errors++; $display("FAIL rst9_after got %0d want 1", tk_total - base); end
    checks++; if (last_tk !== 10'b1000000000) begin errors++; $display("FAIL rst9_code got %b want 1000000000", last_tk); end
    pressed = '0;
    step(60);
  endtask

  task automatic test_strobe_shape;
    checks++; if (wide_total != 0) begin errors++; $display("FAIL strobe_width got %0d want 0", wide_total); end
    checks++; if (multi_total != 0) begin errors++; $display("FAIL strobe_onehot got %0d want 0", multi_total); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_function_keys();
    test_rearm_reset();
    test_strobe_shape();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
